// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU MEM stage (C) and the DMA/debug port (D).
// Latches one request, drives the DM for one cycle and returns a one-cycle ack.
module dm_arbiter #(
  parameter logic [31:0] MEM_LIMIT = 32'h0000_3000,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] c_pc,
  output logic        c_ack,
  output logic        c_err,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  logic        gnt_d, last_d;
  logic        we_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;

  logic        any_req, pick_d;
  logic        s_we, s_err;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_pc;
  logic [31:0] shifted, rd_next;
  logic        rsp;

  assign any_req = c_req | d_req;

  // D wins when alone, or on a tie when round-robin says C went last
  assign pick_d = d_req & (~c_req | (~FIXED_PRI & ~last_d));

  always_comb begin
    s_we    = pick_d ? d_we    : c_we;
    s_size  = pick_d ? d_size  : c_size;
    s_addr  = pick_d ? d_addr  : c_addr;
    s_wdata = pick_d ? d_wdata : c_wdata;
    s_pc    = pick_d ? 32'h0   : c_pc;
    s_err   = (s_size == 2'd3)
            | ((s_size == 2'd1) & s_addr[0])
            | ((s_size == 2'd2) & (|s_addr[1:0]))
            | (s_addr >= MEM_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_d   <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_d   <= pick_d;
        last_d  <= pick_d;
        we_q    <= s_we;
        err_q   <= s_err;
        size_q  <= s_size;
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
        pc_q    <= s_pc;
      end
      if (state == ACCESS) rdata_q <= rd_next;
    end
  end

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_next = 32'h0;
    if (!err_q) begin
      unique case (size_q)
        2'd0:    rd_next = {24'h0, shifted[7:0]};
        2'd1:    rd_next = {16'h0, shifted[15:0]};
        default: rd_next = shifted;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (state == ACCESS) begin
      mem_we = we_q & ~err_q & ~reset;
      unique case (size_q)
        2'd0: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        2'd2: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: begin
          mem_be    = 4'b0000;
          mem_wdata = 32'h0;
        end
      endcase
    end
  end

  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_pc   = pc_q;

  assign rsp     = (state == RESP) & ~reset;
  assign c_ack   = rsp & ~gnt_d;
  assign d_ack   = rsp & gnt_d;
  assign c_err   = c_ack & err_q;
  assign d_err   = d_ack & err_q;
  assign c_rdata = c_ack ? rdata_q : 32'h0;
  assign d_rdata = d_ack ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: byte-level memory reference model, directed
// cases, randomized traffic, arbitration ties and reset abort.
module tb_dm_arbiter;

  localparam logic [31:0] LIM = 32'h0000_3000;
  localparam int NW = 3072;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fill = 1'b1;
  always #5 clk = ~clk;

  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [1:0]  c_size = 0, d_size = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, c_pc = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic        c_ack, c_err, d_ack, d_err, mem_we;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [3:0]  mem_be;

  logic        c2_req = 0, d2_req = 0;
  logic        c2_ack, c2_err, d2_ack, d2_err, m2_we;
  logic [31:0] c2_rdata, d2_rdata, m2_addr, m2_wdata, m2_pc;
  logic [3:0]  m2_be;

  int checks = 0;
  int failures = 0;

  logic [31:0] tmem [0:NW-1];
  logic [7:0]  rmem [0:4*NW-1];

  function automatic logic [31:0] seed(int i);
    return (i * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < NW; i++) tmem[i] <= seed(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tmem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata = (mem_addr < LIM) ? tmem[mem_addr[13:2]] : 32'h5A5A_5A5A;

  dm_arbiter #(.MEM_LIMIT(LIM), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_pc(c_pc),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.MEM_LIMIT(LIM), .FIXED_PRI(1'b1)) dut_fix (
    .clk(clk), .reset(reset),
    .c_req(c2_req), .c_we(1'b0), .c_size(2'd2), .c_addr(32'h0),
    .c_wdata(32'h0), .c_pc(32'h0),
    .c_ack(c2_ack), .c_err(c2_err), .c_rdata(c2_rdata),
    .d_req(d2_req), .d_we(1'b0), .d_size(2'd2), .d_addr(32'h4),
    .d_wdata(32'h0),
    .d_ack(d2_ack), .d_err(d2_err), .d_rdata(d2_rdata),
    .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_be(m2_be), .mem_pc(m2_pc), .mem_rdata(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit isd, input bit we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] pc, output logic [31:0] rd_o);
    int n, cyc, wecnt;
    bit got, xerr;
    logic [31:0] xrd, xwd;
    logic [3:0] xbe;
    logic ack, oack, err;
    logic [31:0] rd;
    n = 1 << sz;
    xerr = (sz == 2'd3) || (a % n != 0) || (a >= LIM);
    xrd = 0;
    xbe = 0;
    xwd = 0;
    if (!xerr) begin
      for (int i = 0; i < n; i++) begin
        xrd = xrd | (32'(rmem[a + i]) << (8 * i));
        xbe[(a % 4) + i] = 1'b1;
      end
      for (int k = 0; k < 4; k++) xwd[8*k +: 8] = wd[8*(k % n) +: 8];
    end
    @(negedge clk);
    if (isd) begin
      d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    end else begin
      c_req = 1; c_we = we; c_size = sz; c_addr = a; c_wdata = wd; c_pc = pc;
    end
    cyc = 0; wecnt = 0; got = 0; rd_o = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        wecnt++;
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(xbe));
        chk("mem_wdata", mem_wdata, xwd);
        chk("mem_pc", mem_pc, isd ? 32'h0 : pc);
      end
      ack  = isd ? d_ack : c_ack;
      oack = isd ? c_ack : d_ack;
      err  = isd ? d_err : c_err;
      rd   = isd ? d_rdata : c_rdata;
      if (ack) begin
        got = 1;
        rd_o = rd;
        chk("latency", cyc, 2);
        chk("other_ack", 32'(oack), 0);
        chk("err", 32'(err), 32'(xerr));
        chk("rdata", rd, xrd);
        chk("we_count", wecnt, (we && !xerr) ? 1 : 0);
        if (isd) d_req = 0;
        else     c_req = 0;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      c_req = 0;
      d_req = 0;
    end
    if (we && !xerr)
      for (int i = 0; i < n; i++) rmem[a + i] = wd[8*i +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  logic [31:0] rd;
  logic [31:0] ra;
  int got_d, waited;
  bit seen;

  initial begin
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++) rmem[4*w + b] = seed(w) >> (8 * b);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c_ack", 32'(c_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_c_err", 32'(c_err), 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_pc", mem_pc, 0);
    fill = 0;
    reset = 0;

    xfer(0, 1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h100, rd);
    xfer(0, 1, 2'd0, 32'h13, 32'h0000_00AB, 32'h104, rd);
    xfer(0, 0, 2'd2, 32'h10, 32'h0, 32'h108, rd);
    chk("lw_after_sb", rd, 32'hABAD_BEEF);
    xfer(1, 0, 2'd1, 32'h12, 32'h0, 32'h0, rd);
    chk("lh_0x12", rd, 32'h0000_ABAD);
    xfer(0, 0, 2'd1, 32'h11, 32'h0, 32'h10C, rd);
    xfer(0, 1, 2'd2, 32'h3000, 32'h1234_5678, 32'h110, rd);
    xfer(1, 1, 2'd3, 32'h20, 32'h1234_5678, 32'h0, rd);
    xfer(0, 0, 2'd2, 32'h2FFC, 32'h0, 32'h114, rd);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) ra = 32'h2FF0 + $urandom_range(0, 31);
      else                           ra = $urandom_range(0, 63);
      xfer($urandom_range(0, 1), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), ra, $urandom, $urandom, rd);
    end

    // reset lands in the ACCESS cycle of a store
    @(negedge clk);
    c_req = 1; c_we = 1; c_size = 2'd2; c_addr = 32'h20;
    c_wdata = 32'h1122_3344; c_pc = 32'h200;
    @(negedge clk);
    chk("abort_we_pre", 32'(mem_we), 1);
    reset = 1;
    c_req = 0;
    #1;
    chk("abort_we_rst", 32'(mem_we), 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c_ack || d_ack || mem_we) seen = 1;
    end
    chk("abort_quiet", 32'(seen), 0);
    xfer(0, 0, 2'd2, 32'h20, 32'h0, 32'h204, rd);

    // round-robin ties, starting from reset
    do_reset();
    @(negedge clk);
    c_req = 1; c_we = 0; c_size = 2'd2; c_addr = 32'h0;
    d_req = 1; d_we = 0; d_size = 2'd2; d_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!(c_ack || d_ack) && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      got_d = d_ack;
      chk("rr_ack_seen", 32'(c_ack | d_ack), 1);
      chk("rr_grant", got_d, k % 2);
      if (got_d != 0) d_req = 0;
      else            c_req = 0;
      @(negedge clk);
      c_req = 1;
      d_req = 1;
    end
    c_req = 0;
    d_req = 0;

    // fixed priority: C wins every tie
    do_reset();
    @(negedge clk);
    c2_req = 1;
    d2_req = 1;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!(c2_ack || d2_ack) && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      chk("fix_c_ack", 32'(c2_ack), 1);
      chk("fix_d_ack", 32'(d2_ack), 0);
      c2_req = 0;
      @(negedge clk);
      c2_req = 1;
    end
    c2_req = 0;
    d2_req = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
